// File: rtl/cskip_adder_pipe_if.sv
// Streaming operand/result bundle for cskip_adder_pipe.
// The master is the producer and consumer environment. The slave is the adder.
interface cskip_adder_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with BLOCK-bit skip groups and a register after
// every STAGE_BLOCKS groups. One global advance signal stalls all stages together.
module cskip_adder_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BLOCK        = 4,
  parameter int unsigned STAGE_BLOCKS = 2
) (
  input logic               clk,
  input logic               rst_n,
  cskip_adder_pipe_if.slave bus
);
  localparam int unsigned NUM_BLK = WIDTH / BLOCK;
  localparam int unsigned STAGES  = (NUM_BLK + STAGE_BLOCKS - 1) / STAGE_BLOCKS;

  logic out_v;
  logic adv;

  assign adv          = ~out_v | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int unsigned LO = k * STAGE_BLOCKS * BLOCK;
    localparam int unsigned HI = (((k + 1) * STAGE_BLOCKS < NUM_BLK) ?
                                  (k + 1) * STAGE_BLOCKS : NUM_BLK) * BLOCK;
    localparam int unsigned NW = WIDTH - LO;
    localparam int unsigned GB = HI - LO;
    localparam int unsigned NG = GB / BLOCK;

    // a_in/b_in hold only the operand bits not yet summed; bit 0 is bit LO of the word.
    logic [NW-1:0] a_in;
    logic [NW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [GB-1:0] ps;
    logic [HI-1:0] s_d;
    logic [HI-1:0] s_q;
    logic          c_d;
    logic          c_q;
    logic          v_q;
    logic          cc;
    logic          pg;
    logic          rc;
    logic          x;

    if (k == 0) begin : src
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub | bus.cin;
      assign v_in = bus.in_valid;
      assign s_d  = ps;
    end else begin : src
      assign a_in = stg[k-1].mid.a_q;
      assign b_in = stg[k-1].mid.b_q;
      assign c_in = stg[k-1].c_q;
      assign v_in = stg[k-1].v_q;
      assign s_d  = {ps, stg[k-1].s_q};
    end

    always_comb begin
      ps = '0;
      cc = c_in;
      pg = 1'b0;
      rc = 1'b0;
      x  = 1'b0;
      for (int unsigned g = 0; g < NG; g++) begin
        pg = 1'b1;
        rc = cc;
        for (int unsigned i = 0; i < BLOCK; i++) begin
          x                 = a_in[g*BLOCK+i] ^ b_in[g*BLOCK+i];
          pg                = pg & x;
          ps[g*BLOCK+i]     = x ^ rc;
          rc                = (a_in[g*BLOCK+i] & b_in[g*BLOCK+i]) | (x & rc);
        end
        // Skip path: an all-propagate group forwards its incoming carry unchanged.
        cc = (pg & cc) | rc;
      end
      c_d = cc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : mid
      logic [NW-GB-1:0] a_q;
      logic [NW-GB-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[NW-1:GB];
          b_q <= b_in[NW-1:GB];
        end
      end
    end

    if (k == STAGES - 1) begin : fin
      logic o_d;
      logic o_q;

      assign o_d = (a_in[NW-1] == b_in[NW-1]) & (ps[GB-1] != a_in[NW-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_q <= 1'b0;
        end else if (adv) begin
          o_q <= o_d;
        end
      end

      assign out_v         = v_q;
      assign bus.out_valid = v_q;
      assign bus.sum       = s_q;
      assign bus.cout      = c_q;
      assign bus.ovf       = o_q;
    end
  end
endmodule

// File: doc/cskip_adder_pipe.md
Name: cskip_adder_pipe

Overview:
- Parametrised, pipelined carry-skip adder/subtractor for wide datapaths.
- Operands are split into BLOCK-bit ripple groups. Each group has skip logic: its carry-in bypasses the group when every bit position propagates.
- Pipeline registers are placed after every STAGE_BLOCKS groups, so latency and throughput are set by parameters.
- A valid/ready handshake on input and output lets it sit between streaming producers and consumers in the arithmetic units.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of BLOCK and ≥ BLOCK.
- BLOCK, 4: bits per ripple-carry group. NUM_BLK = WIDTH/BLOCK.
- STAGE_BLOCKS, 2: groups evaluated per pipeline stage. STAGES = ceil(NUM_BLK/STAGE_BLOCKS), and STAGES ≥ 1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used when sub=0
- sub  in  1  0: A+B+cin; 1: A-B (computed as A+~B+1; cin ignored)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result bits
- cout  out  1  carry out of MSB. When sub=1 this is the not-borrow flag.
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Only one clock and one reset exist: clk, and rst_n (asynchronous assert, active-low). Release is synchronised externally.
- Reset: all stage valid bits are 0, so out_valid=0. sum=0, cout=0, ovf=0. in_ready=1 once rst_n is high.
- Datapath per group g:
  - The operand is b_eff = sub ? ~b : b, and c0 = sub ? 1 : cin.
  - The group computes ripple sum bits and ripple carry-out rc_g.
  - Skip: P_g = AND over i of (a_i XOR b_eff_i). The group's carry-out is c_{g+1} = (P_g & c_g) | rc_g.
  - Propagate uses XOR, not OR, so the skip path is exact for all inputs.
- Pipeline:
  - Stage k holds the groups k*STAGE_BLOCKS .. min((k+1)*STAGE_BLOCKS, NUM_BLK)-1.
  - Each stage register carries: the upper operand bits still to be processed (already inverted if sub), the completed low sum bits, the boundary carry, the MSB operand sign bits needed for ovf, and a valid bit.
- Latency: a beat accepted in cycle T appears on out_valid in cycle T+STAGES when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - adv = ~out_valid | out_ready, and in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When adv=0 every stage holds, including bubbles.
  - out_valid and the output data stay stable until out_ready is seen high.
  - in_valid is allowed to toggle freely. Bubbles (in_valid=0 when accepted) propagate as valid=0 slots.
- ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), evaluated in the final stage.
- Boundary cases:
  - All-propagate operands must pass the carry from c0 to cout through every skip path.
  - When NUM_BLK is not a multiple of STAGE_BLOCKS, the last stage is short.
  - When STAGES=1 the block is a single registered stage.
  - Reset asserted mid-stream discards all in-flight beats. out_valid falls asynchronously.
  - Simultaneous accept and output drain in the same cycle loses no beat and duplicates none.

Test Plan:
- Basic add, WIDTH=32/BLOCK=4/STAGE_BLOCKS=2, out_ready=1: a=0x0000_0001, b=0x0000_0002, cin=0 → 4 cycles later sum=0x0000_0003, cout=0, ovf=0.
- Full skip chain: a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, ovf=1.
- Subtract: sub=1, a=5, b=7 → sum=0xFFFF_FFFE, cout=0. Then a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-pressure: stream 10 beats of a=i, b=i; hold out_ready=0 for cycles 6–9 → in_ready=0 during the stall. Results 2i appear in order with none lost or duplicated, and the output is stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately. After release the first output is the next accepted beat.
- Parameter sweep (WIDTH 8/16/64, BLOCK 2/4/8, STAGE_BLOCKS 1/3/NUM_BLK): 10k random add/sub beats with random valid/ready → all results match the reference model, and latency equals STAGES.
